// File: rtl/wb_load_extend_skid_reg.sv
`default_nettype none
// wb_load_extend_skid_reg: formats raw load data (lane select + sign/zero extend)
// and holds it in a main+skid valid/ready register on the write-back path.
module wb_load_extend_skid_reg #(
  parameter int NrOfBits    = 32,
  parameter int RegAddrBits = 5,
  localparam int AddrLoBits = $clog2(NrOfBits / 8)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   ClockEnable,
  input  logic                   Tick,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NrOfBits-1:0]    in_data,
  input  logic [AddrLoBits-1:0]  in_addr_lo,
  input  logic [2:0]             in_mode,
  input  logic [RegAddrBits-1:0] in_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NrOfBits-1:0]    out_data,
  output logic [RegAddrBits-1:0] out_rd,
  output logic                   out_misalign,
  input  logic                   cs
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic [NrOfBits-1:0]    main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [RegAddrBits-1:0] main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic                   main_mis_q, main_mis_d, skid_mis_q, skid_mis_d;

  logic                adv, accept, consume;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [NrOfBits-1:0] word_sext, word_zext, fmt_data;
  logic                word_mis, fmt_mis;

  assign byte_lane = in_data[{in_addr_lo, 3'b000} +: 8];
  assign half_lane = in_data[{in_addr_lo[AddrLoBits-1:1], 4'b0000} +: 16];
  assign word_mis  = (in_addr_lo[1:0] != 2'b00);

  // Word lane only exists on 64-bit builds; a 32-bit word is the whole bus.
  if (NrOfBits == 64) begin : g_word64
    logic [31:0] word_lane;
    assign word_lane = in_data[{in_addr_lo[AddrLoBits-1], 5'b00000} +: 32];
    assign word_sext = {{(NrOfBits-32){word_lane[31]}}, word_lane};
    assign word_zext = {{(NrOfBits-32){1'b0}}, word_lane};
  end else begin : g_word32
    assign word_sext = in_data;
    assign word_zext = in_data;
  end

  always_comb begin
    fmt_data = in_data;
    fmt_mis  = 1'b0;
    case (in_mode)
      3'd0: fmt_data = {{(NrOfBits-8){byte_lane[7]}}, byte_lane};
      3'd1: fmt_data = {{(NrOfBits-8){1'b0}}, byte_lane};
      3'd2: begin
        fmt_data = {{(NrOfBits-16){half_lane[15]}}, half_lane};
        fmt_mis  = in_addr_lo[0];
      end
      3'd3: begin
        fmt_data = {{(NrOfBits-16){1'b0}}, half_lane};
        fmt_mis  = in_addr_lo[0];
      end
      3'd4: begin
        fmt_data = word_sext;
        fmt_mis  = word_mis;
      end
      3'd5: begin
        // LWU degenerates to RAW on a 32-bit build.
        if (NrOfBits == 64) begin
          fmt_data = word_zext;
          fmt_mis  = word_mis;
        end
      end
      default: ;
    endcase
  end

  assign adv       = ClockEnable & Tick;
  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign accept    = adv & in_valid & in_ready;
  assign consume   = adv & out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_mis_d  = main_mis_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_mis_d  = skid_mis_q;
    if (adv && flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (consume && !accept) state_d = EMPTY;
          else if (accept && !consume) state_d = FULL;
        end
        FULL: if (consume) state_d = ONE;
        default: state_d = EMPTY;
      endcase
      if (accept && (state_q == EMPTY || consume)) begin
        main_data_d = fmt_data;
        main_rd_d   = in_rd;
        main_mis_d  = fmt_mis;
      end else if (accept) begin
        skid_data_d = fmt_data;
        skid_rd_d   = in_rd;
        skid_mis_d  = fmt_mis;
      end else if (consume && state_q == FULL) begin
        main_data_d = skid_data_q;
        main_rd_d   = skid_rd_q;
        main_mis_d  = skid_mis_q;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_mis_q  <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_mis_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_mis_q  <= main_mis_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_mis_q  <= skid_mis_d;
    end
  end

  assign out_data     = cs ? {NrOfBits{1'bz}} : main_data_q;
  assign out_rd       = main_rd_q;
  assign out_misalign = main_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_load_extend_skid_reg.sv
`default_nettype none
// Randomised + directed bench for wb_load_extend_skid_reg against a queue model.
module tb_wb_load_extend_skid_reg;

  localparam int N = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        mis;
  } ent_t;

  logic        Clock, Reset, ClockEnable, Tick, flush, in_valid, out_ready, cs;
  logic [31:0] in_data;
  logic [1:0]  in_addr_lo;
  logic [2:0]  in_mode;
  logic [4:0]  in_rd;
  wire         in_ready, out_valid, out_misalign;
  wire  [31:0] out_data;
  wire  [4:0]  out_rd;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t q[$];

  wb_load_extend_skid_reg #(.NrOfBits(N), .RegAddrBits(5)) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_addr_lo(in_addr_lo), .in_mode(in_mode), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_misalign(out_misalign), .cs(cs)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Load formatting from the ISA rules, using integer arithmetic.
  function automatic ent_t ref_fmt(input logic [31:0] d, input int a, input int m,
                                   input logic [4:0] rd);
    ent_t e;
    longint b, h;
    b = (longint'(d) >> (8 * a)) & 'hFF;
    h = (longint'(d) >> (16 * (a / 2))) & 'hFFFF;
    e.rd  = rd;
    e.mis = 1'b0;
    e.d   = d;
    case (m)
      0: e.d = 32'(b >= 128 ? b - 256 : b);
      1: e.d = 32'(b);
      2: begin e.d = 32'(h >= 32768 ? h - 65536 : h); e.mis = (a % 2) != 0; end
      3: begin e.d = 32'(h); e.mis = (a % 2) != 0; end
      4: e.mis = (a != 0);
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input logic ce, input logic tk, input logic fl, input logic iv,
                      input logic ordy, input logic [31:0] d, input int a, input int m,
                      input logic [4:0] r);
    bit acc, con;
    ClockEnable = ce; Tick = tk; flush = fl; in_valid = iv; out_ready = ordy;
    in_data = d; in_addr_lo = 2'(a); in_mode = 3'(m); in_rd = r;
    @(posedge Clock);
    if (ce && tk) begin
      if (fl) q.delete();
      else begin
        acc = iv && (q.size() < 2);
        con = ordy && (q.size() > 0);
        if (con) void'(q.pop_front());
        if (acc) q.push_back(ref_fmt(d, a, m, r));
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; cs = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rd !== 5'd0 ||
        out_misalign !== 1'b0 || out_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset: valid=%b ready=%b rd=%0d mis=%b data=%h want 0 1 0 0 00000000",
               out_valid, in_ready, out_rd, out_misalign, out_data);
    end
  endtask

  task automatic test_extend();
    logic [31:0] want [4] = '{32'h0000_8001, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_5678};
    logic [31:0] din  [4] = '{32'h8001_F0A5, 32'h0000_80FF, 32'h0000_80FF, 32'h1234_5678};
    int          adr  [4] = '{2, 1, 1, 1};
    int          mde  [4] = '{3, 0, 1, 2};
    logic        wmis [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1, 1, din[i], adr[i], mde[i], 5'(i + 3));
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== want[i] || out_misalign !== wmis[i] ||
          out_rd !== 5'(i + 3)) begin
        n_err++;
        $display("FAIL extend[%0d]: valid=%b data=%h mis=%b rd=%0d want 1 %h %b %0d",
                 i, out_valid, out_data, out_misalign, out_rd, want[i], wmis[i], i + 3);
      end
      step(1, 1, 0, 0, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_misalign();
    step(1, 1, 0, 1, 1, 32'h1234_5678, 3, 4, 5'd9);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_misalign !== 1'b1) begin
      n_err++;
      $display("FAIL lw_misalign: valid=%b data=%h mis=%b want 1 12345678 1",
               out_valid, out_data, out_misalign);
    end
    step(1, 1, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, v[i], 0, 7, 5'(i + 1));
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== v[0]) begin
      n_err++;
      $display("FAIL b2b_full: valid=%b ready=%b data=%h want 1 0 %h",
               out_valid, in_ready, out_data, v[0]);
    end
    step(1, 1, 0, 1, 1, v[2], 0, 7, 5'd3);
    n_vec++;
    if (out_data !== v[1] || out_rd !== 5'd2 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: data=%h rd=%0d ready=%b want %h 2 1",
               out_data, out_rd, in_ready, v[1]);
    end
    step(1, 1, 0, 1, 1, v[2], 0, 7, 5'd3);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== v[2] || out_rd !== 5'd3) begin
      n_err++;
      $display("FAIL b2b_third: valid=%b data=%h rd=%0d want 1 %h 3",
               out_valid, out_data, out_rd, v[2]);
    end
    step(1, 1, 0, 0, 1, 0, 0, 0, 0);
    n_vec++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    step(1, 1, 0, 1, 0, 32'h1111_1111, 0, 7, 5'd1);
    step(1, 1, 0, 1, 0, 32'h2222_2222, 0, 7, 5'd2);
    step(1, 0, 1, 1, 0, 32'h3333_3333, 0, 7, 5'd3);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h1111_1111) begin
      n_err++;
      $display("FAIL flush_noadv: valid=%b ready=%b data=%h want 1 0 11111111",
               out_valid, in_ready, out_data);
    end
    step(1, 1, 1, 1, 0, 32'h4444_4444, 0, 7, 5'd4);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_adv: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_dropped: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset_cs();
    step(1, 1, 0, 1, 0, 32'h5555_5555, 0, 7, 5'd5);
    step(1, 1, 0, 1, 0, 32'h6666_6666, 0, 7, 5'd6);
    Reset = 1'b0;
    #1;
    q.delete();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b ready=%b data=%h want 0 1 00000000",
               out_valid, in_ready, out_data);
    end
    #1 Reset = 1'b1;
    cs = 1'b1;
    step(1, 1, 0, 1, 0, 32'h7777_7777, 0, 7, 5'd7);
    n_vec++;
    if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_data === 32'h7777_7777) begin
      n_err++;
      $display("FAIL cs_tristate: valid=%b rd=%0d data=%h want 1 7 undriven",
               out_valid, out_rd, out_data);
    end
    cs = 1'b0;
    #1;
    n_vec++;
    if (out_data !== 32'h7777_7777) begin
      n_err++;
      $display("FAIL cs_drive: data=%h want 77777777", out_data);
    end
    step(1, 1, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 19) == 0), 1'($urandom), ($urandom_range(0, 2) != 0),
           $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           5'($urandom));
      n_vec++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        n_err++;
        $display("FAIL rand_flags[%0d]: valid=%b ready=%b want %b %b", i,
                 out_valid, in_ready, q.size() != 0, q.size() < 2);
      end else if (q.size() != 0) begin
        n_vec++;
        if (out_data !== q[0].d || out_rd !== q[0].rd || out_misalign !== q[0].mis) begin
          n_err++;
          $display("FAIL rand_data[%0d]: data=%h rd=%0d mis=%b want %h %0d %b", i,
                   out_data, out_rd, out_misalign, q[0].d, q[0].rd, q[0].mis);
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b0; ClockEnable = 0; Tick = 0; flush = 0; in_valid = 0;
    out_ready = 0; cs = 0; in_data = '0; in_addr_lo = '0; in_mode = '0; in_rd = '0;
    test_reset();
    test_extend();
    test_misalign();
    test_back_to_back();
    test_flush();
    test_async_reset_cs();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
